alarm_scheduler: RTL and testbench

- Multi-channel periodic alarm scheduler driven by the free-running seconds timer (`pps` strobe plus `second` count).
- Each channel is programmed with a period in seconds and counts `pps` pulses.
- On expiry, a channel raises a pending request. Pending requests share a single event output, granted round-robin, one event at a time, through a valid/ready handshake.
- Sits between the timer and downstream consumers (LED and UART housekeeping tasks).

---
 rtl/alarm_scheduler_pkg.sv | 31 +++
 rtl/alarm_scheduler_if.sv | 20 ++
 rtl/alarm_rr_arbiter.sv | 31 +++
 rtl/alarm_scheduler.sv | 172 +++++++++++++++++
 tb/tb_alarm_scheduler.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_scheduler_pkg.sv
// alarm_scheduler_pkg
//   Shared types and helpers for the alarm scheduler slice.
//   - N_CH_DEF / SEC_W_DEF : default channel count and seconds width
//   - ch_cfg_t             : per-channel programmed configuration
//   - evt_t                : one delivered event (channel + stamped second)
//   - rr_wrap()            : circular index helper used by the arbiter
package alarm_scheduler_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int SEC_W_DEF = 16;
  localparam int CH_W_DEF  = $clog2(N_CH_DEF);

  typedef struct packed {
    logic                 en;
    logic [SEC_W_DEF-1:0] period;
    logic                 oneshot;
  } ch_cfg_t;

  typedef struct packed {
    logic [CH_W_DEF-1:0]  ch;
    logic [SEC_W_DEF-1:0] second;
  } evt_t;

  // (base + off) mod n for base < n and off < n, without a divider.
  function automatic int rr_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/alarm_scheduler_if.sv
// alarm_scheduler_if
//   Event output channel of the alarm scheduler.
//   Handshake: an event transfers on a clock edge where evt_valid and
//   evt_ready are both 1. While evt_valid=1 and evt_ready=0 the producer
//   holds evt_ch/evt_second stable; evt_valid never depends on evt_ready.
//   Signals: evt_valid, evt_ready, evt_ch[CH_W], evt_second[SEC_W]
//   Modports: master (scheduler side), slave (consumer side)
interface alarm_scheduler_if #(
  parameter int N_CH  = 4,
  parameter int SEC_W = 16,
  parameter int CH_W  = $clog2(N_CH)
) ();
  logic             evt_valid;
  logic             evt_ready;
  logic [CH_W-1:0]  evt_ch;
  logic [SEC_W-1:0] evt_second;

  modport master (output evt_valid, output evt_ch, output evt_second, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, input evt_second, output evt_ready);
endinterface

// File: rtl/alarm_rr_arbiter.sv
// alarm_rr_arbiter
//   Combinational round-robin search: first set request at or after ptr_i,
//   wrapping around. The pointer register lives in the parent.
//   Ports: req_i[N_CH] requests, ptr_i search start, en_i grant enable,
//          gnt_o granted index, gnt_vld_o a grant was made.
module alarm_rr_arbiter
  import alarm_scheduler_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)   // derived; do not override
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CH_W-1:0] ptr_i,
  input  logic            en_i,
  output logic [CH_W-1:0] gnt_o,
  output logic            gnt_vld_o
);

  always_comb begin
    gnt_o     = '0;
    gnt_vld_o = 1'b0;
    // Scan from the farthest offset down so the nearest match wins last.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (en_i && req_i[CH_W'(rr_wrap(int'(ptr_i), i, N_CH))]) begin
        gnt_o     = CH_W'(rr_wrap(int'(ptr_i), i, N_CH));
        gnt_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alarm_scheduler.sv
// alarm_scheduler
//   Multi-channel periodic alarm scheduler counting pps pulses. Expired
//   channels raise pending flags which are delivered one at a time,
//   round-robin, through a single-entry event register.
//   Ports: clk_50m, rst (sync, active-high), pps, second[SEC_W],
//          cfg_we/cfg_ch/cfg_en/cfg_period (config write, always accepted),
//          evt (alarm_scheduler_if.master: evt_valid/ready/ch/second),
//          pending[N_CH], overrun[N_CH] (sticky), dbg_rr_ptr_o (RR pointer).
//   Build option ALARM_SCHEDULER_ONESHOT_EN adds cfg_oneshot: a one-shot
//   channel clears its enable at its first expiry.
module alarm_scheduler
  import alarm_scheduler_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int SEC_W = SEC_W_DEF,
  parameter int CH_W  = $clog2(N_CH)  // derived; do not override
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic             pps,
  input  logic [SEC_W-1:0] second,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic             cfg_en,
  input  logic [SEC_W-1:0] cfg_period,
`ifdef ALARM_SCHEDULER_ONESHOT_EN
  input  logic             cfg_oneshot,
`endif
  alarm_scheduler_if.master evt,
  output logic [N_CH-1:0]  pending,
  output logic [N_CH-1:0]  overrun,
  output logic [CH_W-1:0]  dbg_rr_ptr_o
);

  logic [N_CH-1:0]  en_q, en_d, pend_q, pend_d, ovr_q, ovr_d;
  logic [SEC_W-1:0] per_q[N_CH], per_d[N_CH];
  logic [SEC_W-1:0] cnt_q[N_CH], cnt_d[N_CH];
  logic [SEC_W-1:0] stamp_q[N_CH], stamp_d[N_CH];
`ifdef ALARM_SCHEDULER_ONESHOT_EN
  logic [N_CH-1:0]  os_q, os_d;
`endif
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic             evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]  evt_ch_q, evt_ch_d;
  logic [SEC_W-1:0] evt_sec_q, evt_sec_d;

  logic [N_CH-1:0]  wr, act, gr;
  logic [CH_W-1:0]  gnt;
  logic             gnt_vld, load;

  // The output register reloads when empty or when its event leaves now.
  assign load = !evt_valid_q || evt.evt_ready;

  alarm_rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
    .req_i     (pend_q),
    .ptr_i     (ptr_q),
    .en_i      (load),
    .gnt_o     (gnt),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    wr  = '0;
    act = '0;
    gr  = '0;
    for (int c = 0; c < N_CH; c++) begin
      wr[c]  = cfg_we && (cfg_ch == CH_W'(c));
      act[c] = en_q[c] && (per_q[c] != '0);
      gr[c]  = gnt_vld && (gnt == CH_W'(c));
    end
  end

  always_comb begin
    en_d   = en_q;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    per_d  = per_q;
    cnt_d  = cnt_q;
    stamp_d = stamp_q;
`ifdef ALARM_SCHEDULER_ONESHOT_EN
    os_d   = os_q;
`endif
    for (int c = 0; c < N_CH; c++) begin
      if (wr[c]) begin
        // A config write overrides counting on this edge entirely.
        en_d[c]   = cfg_en;
        per_d[c]  = cfg_period;
        cnt_d[c]  = cfg_period;
        pend_d[c] = 1'b0;
        ovr_d[c]  = 1'b0;
`ifdef ALARM_SCHEDULER_ONESHOT_EN
        os_d[c]   = cfg_oneshot;
`endif
      end else begin
        if (gr[c]) pend_d[c] = 1'b0;
        if (pps && act[c]) begin
          if (cnt_q[c] <= SEC_W'(1)) begin
            // A same-cycle grant frees the slot, so this is not an overrun.
            if (pend_q[c] && !gr[c]) ovr_d[c] = 1'b1;
            pend_d[c]  = 1'b1;
            stamp_d[c] = second;
            cnt_d[c]   = per_q[c];
`ifdef ALARM_SCHEDULER_ONESHOT_EN
            if (os_q[c]) en_d[c] = 1'b0;
`endif
          end else begin
            cnt_d[c] = cnt_q[c] - SEC_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_sec_d   = evt_sec_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (gnt_vld) begin
        evt_valid_d = 1'b1;
        evt_ch_d    = gnt;
        evt_sec_d   = stamp_q[gnt];
        ptr_d       = (gnt == CH_W'(N_CH - 1)) ? '0 : gnt + CH_W'(1);
      end else begin
        evt_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      en_q        <= '0;
      pend_q      <= '0;
      ovr_q       <= '0;
`ifdef ALARM_SCHEDULER_ONESHOT_EN
      os_q        <= '0;
`endif
      for (int c = 0; c < N_CH; c++) begin
        per_q[c]   <= '0;
        cnt_q[c]   <= '0;
        stamp_q[c] <= '0;
      end
      ptr_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_sec_q   <= '0;
    end else begin
      en_q        <= en_d;
      pend_q      <= pend_d;
      ovr_q       <= ovr_d;
`ifdef ALARM_SCHEDULER_ONESHOT_EN
      os_q        <= os_d;
`endif
      per_q       <= per_d;
      cnt_q       <= cnt_d;
      stamp_q     <= stamp_d;
      ptr_q       <= ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_sec_q   <= evt_sec_d;
    end
  end

  assign evt.evt_valid  = evt_valid_q;
  assign evt.evt_ch     = evt_ch_q;
  assign evt.evt_second = evt_sec_q;
  assign pending        = pend_q;
  assign overrun        = ovr_q;
  assign dbg_rr_ptr_o   = ptr_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
module tb_alarm_scheduler;
  import alarm_scheduler_pkg::*;

  localparam int N_CH  = 4;
  localparam int SEC_W = 16;
  localparam int CH_W  = 2;
  localparam int EW    = $bits(evt_t);

  // ---------------- clock / reset ----------------
  logic clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  logic             rst, pps, cfg_we, cfg_en;
  logic [SEC_W-1:0] second, cfg_period;
  logic [CH_W-1:0]  cfg_ch, dbg_ptr;
  logic [N_CH-1:0]  pending, overrun;
`ifdef ALARM_SCHEDULER_ONESHOT_EN
  logic             cfg_oneshot;
`endif

  alarm_scheduler_if #(.N_CH(N_CH), .SEC_W(SEC_W)) evt_if ();

  alarm_scheduler #(.N_CH(N_CH), .SEC_W(SEC_W)) dut (
    .clk_50m      (clk_50m),
    .rst          (rst),
    .pps          (pps),
    .second       (second),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_en       (cfg_en),
    .cfg_period   (cfg_period),
`ifdef ALARM_SCHEDULER_ONESHOT_EN
    .cfg_oneshot  (cfg_oneshot),
`endif
    .evt          (evt_if.master),
    .pending      (pending),
    .overrun      (overrun),
    .dbg_rr_ptr_o (dbg_ptr)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];

  always @(posedge clk_50m)
    if (!rst && evt_if.evt_valid && evt_if.evt_ready)
      got_q.push_back({evt_if.evt_ch, evt_if.evt_second});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_evt(input int ch, input int sec);
    exp_q.push_back({CH_W'(ch), SEC_W'(sec)});
  endtask

  task automatic drain_check(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk(tag, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_50m);
      #2;
    end
  endtask

  task automatic cfg(input int ch, input bit en, input int per, input bit os = 1'b0);
    cfg_we     = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_en     = en;
    cfg_period = SEC_W'(per);
`ifdef ALARM_SCHEDULER_ONESHOT_EN
    cfg_oneshot = os;
`endif
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input int sec);
    second = SEC_W'(sec);
    pps    = 1'b1;
    step();
    pps    = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; pps = 1'b0; second = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_en = 1'b0; cfg_period = '0;
`ifdef ALARM_SCHEDULER_ONESHOT_EN
    cfg_oneshot = 1'b0;
`endif
    evt_if.evt_ready = 1'b0;
    step(2);
    chk("rst_valid",   evt_if.evt_valid, 0);
    chk("rst_ch",      evt_if.evt_ch, 0);
    chk("rst_second",  evt_if.evt_second, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ptr",     dbg_ptr, 0);
    rst = 1'b0;

    // ch0 period 3: expiries at seconds 3 and 6
    evt_if.evt_ready = 1'b1;
    cfg(0, 1, 3);
    for (int s = 1; s <= 7; s++) begin
      pulse(s);
      step(9);
    end
    expect_evt(0, 3);
    expect_evt(0, 6);
    drain_check("t1_evt");
    chk("t1_ptr", dbg_ptr, 1);
    cfg(0, 0, 0);

    // ch1 and ch2 period 2 expire together, granted on consecutive cycles
    cfg(1, 1, 2);
    cfg(2, 1, 2);
    pulse(1);
    step(3);
    chk("t2_pend_s1", pending, 0);
    pulse(2);
    chk("t2_pend_both", pending, 4'b0110);
    chk("t2_valid_lat", evt_if.evt_valid, 0);
    step();
    chk("t2_ev1_valid", evt_if.evt_valid, 1);
    chk("t2_ev1_ch",    evt_if.evt_ch, 1);
    chk("t2_ev1_sec",   evt_if.evt_second, 2);
    chk("t2_ptr2",      dbg_ptr, 2);
    step();
    chk("t2_ev2_ch",    evt_if.evt_ch, 2);
    chk("t2_ptr3",      dbg_ptr, 3);
    chk("t2_pend_none", pending, 0);
    step();
    chk("t2_idle", evt_if.evt_valid, 0);
    expect_evt(1, 2);
    expect_evt(2, 2);
    drain_check("t2_evt");
    cfg(1, 0, 0);
    cfg(2, 0, 0);

    // ch0 period 1 with consumer stalled: hold, overrun, restamp
    evt_if.evt_ready = 1'b0;
    cfg(0, 1, 1);
    pulse(1);
    step(3);
    chk("t3_first_valid", evt_if.evt_valid, 1);
    chk("t3_first_sec",   evt_if.evt_second, 1);
    chk("t3_pend_clear",  pending, 0);
    pulse(2);
    step(3);
    chk("t3_no_ovr_yet",  overrun, 0);
    pulse(3);
    step(3);
    chk("t3_hold_ch",     evt_if.evt_ch, 0);
    chk("t3_hold_sec",    evt_if.evt_second, 1);
    chk("t3_overrun",     overrun, 4'b0001);
    chk("t3_pending",     pending, 4'b0001);
    evt_if.evt_ready = 1'b1;
    step();
    chk("t3_second_sec",  evt_if.evt_second, 3);
    chk("t3_pend_taken",  pending, 0);
    step();
    chk("t3_drained",     evt_if.evt_valid, 0);
    cfg(0, 0, 0);
    chk("t3_ovr_cleared", overrun, 0);
    expect_evt(0, 1);
    expect_evt(0, 3);
    drain_check("t3_evt");

    // config write coincident with pps: no decrement on that pulse
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_en = 1'b1; cfg_period = 16'd5;
    second = 16'd10; pps = 1'b1;
    step();
    cfg_we = 1'b0; pps = 1'b0;
    for (int s = 11; s <= 14; s++) begin
      pulse(s);
      step(3);
    end
    chk("t4_no_early_pend",  pending, 0);
    chk("t4_no_early_valid", evt_if.evt_valid, 0);
    pulse(15);
    step(3);
    cfg(3, 1, 0);
    for (int s = 16; s <= 22; s++) begin
      pulse(s);
      step(3);
    end
    chk("t4_p0_silent", pending, 0);
    expect_evt(3, 15);
    drain_check("t4_evt");

    // reset while an event is held and two channels are pending
    evt_if.evt_ready = 1'b0;
    cfg(1, 1, 1);
    cfg(2, 1, 1);
    pulse(30);
    step();
    pulse(31);
    step(2);
    chk("t5_pre_valid",   evt_if.evt_valid, 1);
    chk("t5_pre_ch",      evt_if.evt_ch, 1);
    chk("t5_pre_pending", pending, 4'b0110);
    chk("t5_pre_overrun", overrun, 4'b0100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_valid",   evt_if.evt_valid, 0);
    chk("t5_pending", pending, 0);
    chk("t5_overrun", overrun, 0);
    chk("t5_ptr",     dbg_ptr, 0);
    evt_if.evt_ready = 1'b1;
    for (int s = 32; s <= 35; s++) begin
      pulse(s);
      step(3);
    end
    chk("t5_silent_pend", pending, 0);
    drain_check("t5_evt");

`ifdef ALARM_SCHEDULER_ONESHOT_EN
    // one-shot channel fires once only
    cfg(2, 1, 2, 1'b1);
    for (int s = 1; s <= 4; s++) begin
      pulse(s);
      step(3);
    end
    expect_evt(2, 2);
    drain_check("t6_oneshot");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
